// File: rtl/fifo_pkt_reader.sv
// Pops length-prefixed frames from a first-word-fall-through FIFO and streams them out with keep/last.
// Optional header length check (ERR pulse and frame drop) is enabled by defining FIFO_PKT_READER_LEN_CHECK_EN.
//
// state  | meaning
// S_IDLE | waiting for a header word; pops it and loads the word counter
// S_DATA | forwarding payload words to the output register
// S_DROP | discarding the payload of a rejected header
module fifo_pkt_reader #(
    parameter int          C_WIDTH   = 32,
    parameter int unsigned C_MAX_LEN = 1522,
    localparam int         C_BYTES   = C_WIDTH / 8
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic [C_WIDTH-1:0] FIFO_DATA,
    input  logic               FIFO_EMPTY,
    output logic               FIFO_RD_EN,
    output logic [C_WIDTH-1:0] M_DATA,
    output logic [C_BYTES-1:0] M_KEEP,
    output logic               M_VALID,
    output logic               M_LAST,
    input  logic               M_READY,
    output logic [15:0]        FRAME_CNT,
    output logic               ERR
);

`ifdef FIFO_PKT_READER_LEN_CHECK_EN
    localparam bit LEN_CHK_EN = 1'b1;
`else
    localparam bit LEN_CHK_EN = 1'b0;
`endif

    localparam logic [16:0] BYTES17 = 17'(C_BYTES);
    localparam logic [15:0] BYTES16 = 16'(C_BYTES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_DROP
    } state_t;

    state_t             state;
    logic [15:0]        cnt;
    logic [15:0]        len_q;
    logic [15:0]        hdr_len;
    logic [16:0]        len_sum;
    logic [15:0]        hdr_nw;
    logic [15:0]        len_rem;
    logic               hdr_bad;
    logic               pop;
    logic [C_BYTES-1:0] keep_last;

`ifdef FIFO_PKT_READER_LEN_CHECK_EN
    logic err_q;
    assign ERR = err_q;
`else
    assign ERR = 1'b0;
`endif

    // 17-bit sum so LEN=0xFFFF rounds up without overflow
    assign hdr_len = FIFO_DATA[15:0];
    assign len_sum = {1'b0, hdr_len} + (BYTES17 - 17'd1);
    assign hdr_nw  = 16'(len_sum / BYTES17);
    assign hdr_bad = LEN_CHK_EN && ((hdr_len == 16'd0) || ({16'd0, hdr_len} > C_MAX_LEN));
    assign len_rem = len_q % BYTES16;

    always_comb begin
        for (int i = 0; i < C_BYTES; i++) begin
            keep_last[i] = (len_rem == 16'd0) || (16'(i) < len_rem);
        end
    end

    always_comb begin
        FIFO_RD_EN = 1'b0;
        if (RST_N) begin
            unique case (state)
                S_IDLE:  FIFO_RD_EN = ~FIFO_EMPTY;
                S_DATA:  FIFO_RD_EN = ~FIFO_EMPTY & (~M_VALID | M_READY);
                S_DROP:  FIFO_RD_EN = ~FIFO_EMPTY;
                default: FIFO_RD_EN = 1'b0;
            endcase
        end
    end

    assign pop = FIFO_RD_EN & ~FIFO_EMPTY;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= S_IDLE;
            cnt       <= 16'd0;
            len_q     <= 16'd0;
            M_DATA    <= '0;
            M_KEEP    <= '0;
            M_VALID   <= 1'b0;
            M_LAST    <= 1'b0;
            FRAME_CNT <= 16'd0;
`ifdef FIFO_PKT_READER_LEN_CHECK_EN
            err_q     <= 1'b0;
`endif
        end else begin
`ifdef FIFO_PKT_READER_LEN_CHECK_EN
            err_q <= 1'b0;
`endif
            // a load in S_DATA below overrides this clear
            if (M_VALID && M_READY) begin
                M_VALID <= 1'b0;
                if (M_LAST) begin
                    FRAME_CNT <= FRAME_CNT + 16'd1;
                end
            end

            unique case (state)
                S_IDLE: begin
                    if (pop) begin
                        len_q <= hdr_len;
                        cnt   <= hdr_nw;
`ifdef FIFO_PKT_READER_LEN_CHECK_EN
                        err_q <= hdr_bad;
`endif
                        if (hdr_nw == 16'd0) begin
                            state <= S_IDLE;
                        end else if (hdr_bad) begin
                            state <= S_DROP;
                        end else begin
                            state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (pop) begin
                        M_DATA  <= FIFO_DATA;
                        M_VALID <= 1'b1;
                        M_LAST  <= (cnt == 16'd1);
                        M_KEEP  <= (cnt == 16'd1) ? keep_last : '1;
                        cnt     <= cnt - 16'd1;
                        if (cnt == 16'd1) begin
                            state <= S_IDLE;
                        end
                    end
                end
                S_DROP: begin
                    if (pop) begin
                        cnt <= cnt - 16'd1;
                        if (cnt == 16'd1) begin
                            state <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_pkt_reader.sv
// Directed bench for fifo_pkt_reader: FIFO model feeds frames, a scoreboard queue checks every output transfer.
module tb_fifo_pkt_reader;

    logic        clk;
    logic        rst_n;
    logic [31:0] fifo_data;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic [31:0] m_data;
    logic [3:0]  m_keep;
    logic        m_valid;
    logic        m_last;
    logic        m_ready;
    logic [15:0] frame_cnt;
    logic        err;

    typedef struct {
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
    } exp_t;

    logic [31:0] fifo_q[$];
    exp_t        exp_q[$];
    int          xfer_cyc[$];
    int          compared   = 0;
    int          mismatched = 0;
    int          pops       = 0;
    int          xfers      = 0;
    int          cyc        = 0;
    bit          gap        = 1'b0;

    fifo_pkt_reader #(.C_WIDTH(32), .C_MAX_LEN(1522)) dut (
        .CLK        (clk),
        .RST_N      (rst_n),
        .FIFO_DATA  (fifo_data),
        .FIFO_EMPTY (fifo_empty),
        .FIFO_RD_EN (fifo_rd_en),
        .M_DATA     (m_data),
        .M_KEEP     (m_keep),
        .M_VALID    (m_valid),
        .M_LAST     (m_last),
        .M_READY    (m_ready),
        .FRAME_CNT  (frame_cnt),
        .ERR        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic upd_fifo();
        fifo_empty = gap || (fifo_q.size() == 0);
        fifo_data  = (fifo_q.size() != 0) ? fifo_q[0] : 32'd0;
    endtask

    function automatic logic [3:0] keep_for(input int len);
        case (len % 4)
            1:       return 4'h1;
            2:       return 4'h3;
            3:       return 4'h7;
            default: return 4'hF;
        endcase
    endfunction

    task automatic push_frame(input int len, input logic [31:0] base, input bit fwd);
        int nw;
        exp_t e;
        nw = (len + 3) / 4;
        fifo_q.push_back({16'hC0DE, 16'(len)});
        for (int i = 0; i < nw; i++) begin
            fifo_q.push_back(base + 32'(i));
            if (fwd) begin
                e.d = base + 32'(i);
                e.k = (i == nw - 1) ? keep_for(len) : 4'hF;
                e.l = (i == nw - 1);
                exp_q.push_back(e);
            end
        end
        upd_fifo();
    endtask

    task automatic check_out();
        exp_t e;
        chk("sb_unexpected_output", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("sb_data", 64'(m_data), 64'(e.d));
            chk("sb_keep", 64'(m_keep), 64'(e.k));
            chk("sb_last", 64'(m_last), 64'(e.l));
        end
    endtask

    // samples just after the falling edge, applies FIFO pop just after the rising edge
    task automatic tick();
        bit will_pop;
        @(negedge clk);
        #1;
        will_pop = fifo_rd_en && !fifo_empty;
        if (m_valid && m_ready) begin
            xfers++;
            xfer_cyc.push_back(cyc);
            check_out();
        end
        @(posedge clk);
        #1;
        if (will_pop) begin
            void'(fifo_q.pop_front());
            pops++;
        end
        upd_fifo();
        cyc++;
    endtask

    task automatic drain(input string tag, input int max);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || m_valid) && n < max) begin
            tick();
            n++;
        end
        chk(tag, 64'(n < max), 64'd1);
    endtask

    initial begin
        int p0;
        int x0;
        int n;

        rst_n   = 1'b0;
        m_ready = 1'b1;
        upd_fifo();
        tick();
        tick();
        chk("rst_valid", 64'(m_valid), 64'd0);
        chk("rst_data", 64'(m_data), 64'd0);
        chk("rst_keep", 64'(m_keep), 64'd0);
        chk("rst_last", 64'(m_last), 64'd0);
        chk("rst_frame_cnt", 64'(frame_cnt), 64'd0);
        chk("rst_err", 64'(err), 64'd0);

        // frame A, LEN=10, already waiting when reset releases
        push_frame(10, 32'hA000_0000, 1'b1);
        chk("rst_rd_en_gated", 64'(fifo_rd_en), 64'd0);
        rst_n = 1'b1;
        #1;
        chk("first_pop_after_reset", 64'(fifo_rd_en), 64'd1);
        tick();
        chk("latency_valid_c1", 64'(m_valid), 64'd0);
        tick();
        chk("latency_valid_c2", 64'(m_valid), 64'd1);
        chk("latency_data_c2", 64'(m_data), 64'hA000_0000);
        drain("drain_a", 50);
        chk("frame_cnt_a", 64'(frame_cnt), 64'd1);
        chk("pops_a", 64'(pops), 64'd4);

        // backpressure on the second word
        p0 = pops;
        push_frame(10, 32'hB000_0000, 1'b1);
        tick();
        tick();
        tick();
        m_ready = 1'b0;
        #1;
        chk("bp_no_pop", 64'(fifo_rd_en), 64'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("bp_hold_data", 64'(m_data), 64'hB000_0001);
            chk("bp_hold_valid", 64'(m_valid), 64'd1);
            chk("bp_hold_keep", 64'(m_keep), 64'hF);
            chk("bp_hold_last", 64'(m_last), 64'd0);
        end
        chk("bp_pops_held", 64'(pops - p0), 64'd3);
        m_ready = 1'b1;
        drain("drain_bp", 50);
        chk("bp_pops_total", 64'(pops - p0), 64'd4);
        chk("frame_cnt_bp", 64'(frame_cnt), 64'd2);

        // back-to-back LEN=8 then LEN=4: one bubble for the second header
        xfer_cyc.delete();
        push_frame(8, 32'hC000_0000, 1'b1);
        push_frame(4, 32'hC100_0000, 1'b1);
        drain("drain_b2b", 50);
        chk("b2b_word_count", 64'(xfer_cyc.size()), 64'd3);
        if (xfer_cyc.size() == 3) begin
            chk("b2b_span", 64'(xfer_cyc[2] - xfer_cyc[0]), 64'd3);
        end
        chk("frame_cnt_b2b", 64'(frame_cnt), 64'd4);

        // FIFO runs dry mid-frame
        push_frame(12, 32'hD000_0000, 1'b1);
        tick();
        tick();
        gap = 1'b1;
        upd_fifo();
        for (int k = 0; k < 3; k++) begin
            chk("gap_rd_en", 64'(fifo_rd_en), 64'd0);
            tick();
        end
        gap = 1'b0;
        upd_fifo();
        drain("drain_gap", 50);
        chk("frame_cnt_gap", 64'(frame_cnt), 64'd5);

`ifdef FIFO_PKT_READER_LEN_CHECK_EN
        p0 = pops;
        push_frame(2000, 32'hE000_0000, 1'b0);
        push_frame(4, 32'hE100_0000, 1'b1);
        tick();
        chk("err_pulse_long", 64'(err), 64'd1);
        tick();
        chk("err_clear_long", 64'(err), 64'd0);
        drain("drain_drop", 700);
        chk("drop_pops", 64'(pops - p0), 64'd503);
        push_frame(0, 32'hF000_0000, 1'b0);
        push_frame(4, 32'hF100_0000, 1'b1);
        tick();
        chk("err_pulse_zero", 64'(err), 64'd1);
        tick();
        chk("err_clear_zero", 64'(err), 64'd0);
        drain("drain_zero", 50);
`else
        p0 = pops;
        push_frame(0, 32'hF000_0000, 1'b0);
        push_frame(4, 32'hF100_0000, 1'b1);
        tick();
        chk("err_tied_zero_len", 64'(err), 64'd0);
        drain("drain_zero", 50);
        chk("zero_len_pops", 64'(pops - p0), 64'd3);
        push_frame(1526, 32'hE000_0000, 1'b1);
        drain("drain_long", 700);
        chk("err_tied_long", 64'(err), 64'd0);
`endif
        chk("frame_cnt_cfg", 64'(frame_cnt), 64'd7);

        // LEN=29 under random backpressure, last keep 0x1
        push_frame(29, 32'h1234_0000, 1'b1);
        n = 0;
        while ((exp_q.size() != 0 || m_valid) && n < 300) begin
            m_ready = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        chk("drain_random", 64'(n < 300), 64'd1);
        m_ready = 1'b1;
        chk("frame_cnt_random", 64'(frame_cnt), 64'd8);

        // asynchronous reset in the middle of a LEN=16 frame
        x0 = xfers;
        push_frame(16, 32'h5500_0000, 1'b1);
        n = 0;
        while (xfers - x0 < 2 && n < 50) begin
            tick();
            n++;
        end
        chk("mid_reset_reach", 64'(xfers - x0), 64'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 64'(m_valid), 64'd0);
        chk("async_rst_frame_cnt", 64'(frame_cnt), 64'd0);
        chk("async_rst_last", 64'(m_last), 64'd0);
        chk("async_rst_keep", 64'(m_keep), 64'd0);
        chk("async_rst_rd_en", 64'(fifo_rd_en), 64'd0);
        fifo_q.delete();
        exp_q.delete();
        upd_fifo();
        tick();
        tick();
        rst_n = 1'b1;
        push_frame(4, 32'h6600_0000, 1'b1);
        drain("drain_after_reset", 50);
        chk("frame_cnt_after_reset", 64'(frame_cnt), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
